// File: rtl/hazard_stall_ctrl_pkg.sv
// Pipeline-wide constants shared by the stall controller and the pipeline registers.
package hazard_stall_ctrl_pkg;
    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam logic [1:0]  TNEW_NOW        = 2'd0;
    localparam logic [1:0]  TNEW_ONE        = 2'd1;
    localparam logic [1:0]  TNEW_TWO        = 2'd2;
    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;
    localparam logic [31:0] PC_DEFAULT      = 32'h0000_3000;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard information from D/E/M and the resulting stall controls.
interface hazard_stall_ctrl_if;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        F_en;
    logic        D_en;
    logic        E_flush;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  F_en, D_en, E_flush, md_busy, stall_cycles
    );

    modport slave (
        input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output F_en, D_en, E_flush, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Tracks remaining busy cycles of the multiply/divide unit.
module md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic md_busy
);
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // A start while the unit is still busy is dropped rather than reloading.
    always_comb begin
        cnt_next = cnt_reg;
        if (start && (cnt_reg == '0)) begin
            cnt_next = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign md_busy = (cnt_reg != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall decision from Tuse/Tnew hazards and mult/div occupancy.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);
    logic [4:0]  src_addr [2];
    logic [1:0]  src_tuse [2];
    logic [1:0]  src_stall;
    logic        stall_md;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cycles_reg;

    assign src_addr[0] = bus.D_rs_addr;
    assign src_addr[1] = bus.D_rt_addr;
    assign src_tuse[0] = bus.D_rs_tuse;
    assign src_tuse[1] = bus.D_rt_tuse;

    // Tnew never exceeds 2, so an unused operand (Tuse 3) can never stall.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_stall[gi] = (src_addr[gi] != 5'd0) &&
                ((bus.E_wa == src_addr[gi] && bus.E_tnew > src_tuse[gi]) ||
                 (bus.M_wa == src_addr[gi] && bus.M_tnew > src_tuse[gi]));
        end
    endgenerate

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.E_md_start),
        .div     (bus.E_md_div),
        .md_busy (md_busy)
    );

    assign stall_md = bus.D_is_md && (md_busy || bus.E_md_start);
    assign stall    = (|src_stall) || stall_md;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
        end else if (stall) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign bus.F_en         = !stall;
    assign bus.D_en         = !stall;
    assign bus.E_flush      = stall;
    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = stall_cycles_reg;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor compares.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        f_en;
        logic        d_en;
        logic        e_flush;
        logic        md_busy;
        logic [31:0] stall_cycles;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];
    int total = 0;
    int bad   = 0;

    // Model: the md unit is busy through an absolute cycle number.
    int          now      = 0;
    int          busy_end = -1;
    int unsigned stall_cnt = 0;
    bit          have_prev = 0;
    logic        cur_start, cur_div, cur_stall;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit operand_waits(input logic [4:0] a, input logic [1:0] tuse);
        // The operand must wait if a producer's result arrives later than it is needed.
        int need_in;
        need_in = int'(tuse);
        if (a == 5'd0 || tuse == 2'd3) return 1'b0;
        if (bus.E_wa == a && int'(bus.E_tnew) > need_in) return 1'b1;
        if (bus.M_wa == a && int'(bus.M_tnew) > need_in) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        if (cur_start && !(now <= busy_end))
            busy_end = now + (cur_div ? 10 : 5);
        if (cur_stall) stall_cnt = stall_cnt + 1;
        now++;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] rs_tu, input logic [1:0] rt_tu, input logic md,
                         input logic [4:0] ewa, input logic [1:0] etn,
                         input logic [4:0] mwa, input logic [1:0] mtn,
                         input logic st, input logic dv);
        exp_t e;
        bit busy;
        @(posedge clk);
        if (have_prev) model_step();
        #1;
        bus.D_rs_addr = rs;  bus.D_rt_addr = rt;
        bus.D_rs_tuse = rs_tu; bus.D_rt_tuse = rt_tu; bus.D_is_md = md;
        bus.E_wa = ewa; bus.E_tnew = etn; bus.M_wa = mwa; bus.M_tnew = mtn;
        bus.E_md_start = st; bus.E_md_div = dv;
        busy      = (now <= busy_end);
        cur_start = st;
        cur_div   = dv;
        cur_stall = operand_waits(rs, rs_tu) || operand_waits(rt, rt_tu) || (md && (busy || st));
        e.f_en = !cur_stall; e.d_en = !cur_stall; e.e_flush = cur_stall;
        e.md_busy = busy; e.stall_cycles = stall_cnt; e.cyc = now;
        exp_q.push_back(e);
        have_prev = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // Assert reset between clock edges and check the state cleared without a clock.
    task automatic reset_pulse();
        @(posedge clk);
        if (have_prev) model_step();
        #1;
        bus.D_rs_addr = 5'd0; bus.D_rt_addr = 5'd0; bus.D_rs_tuse = 2'd3; bus.D_rt_tuse = 2'd3;
        bus.D_is_md = 1'b0; bus.E_wa = 5'd0; bus.E_tnew = 2'd0; bus.M_wa = 5'd0; bus.M_tnew = 2'd0;
        bus.E_md_start = 1'b0; bus.E_md_div = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_md_busy", now, 32'(bus.md_busy), 32'd0);
        chk("rst_stall_cycles", now, bus.stall_cycles, 32'd0);
        chk("rst_f_en", now, 32'(bus.F_en), 32'd1);
        chk("rst_e_flush", now, 32'(bus.E_flush), 32'd0);
        busy_end  = -1;
        stall_cnt = 0;
        have_prev = 0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("f_en", e.cyc, 32'(bus.F_en), 32'(e.f_en));
            chk("d_en", e.cyc, 32'(bus.D_en), 32'(e.d_en));
            chk("e_flush", e.cyc, 32'(bus.E_flush), 32'(e.e_flush));
            chk("md_busy", e.cyc, 32'(bus.md_busy), 32'(e.md_busy));
            chk("stall_cycles", e.cyc, bus.stall_cycles, e.stall_cycles);
        end
    end

    initial begin
        bus.D_rs_addr = 5'd0; bus.D_rt_addr = 5'd0; bus.D_rs_tuse = 2'd3; bus.D_rt_tuse = 2'd3;
        bus.D_is_md = 1'b0; bus.E_wa = 5'd0; bus.E_tnew = 2'd0; bus.M_wa = 5'd0; bus.M_tnew = 2'd0;
        bus.E_md_start = 1'b0; bus.E_md_div = 1'b0;
        repeat (2) @(posedge clk);
        reset_pulse();
        idle(2);

        // Load-use: E hit, then M hit with Tnew 1, then M result ready.
        drive(5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        drive(5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 1'b0, 1'b0);
        drive(5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 1'b0, 1'b0);
        // Classic lw/add pair: one stall, then none once lw is in M.
        drive(5'd9, 5'd0, 2'd1, 2'd3, 1'b0, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        drive(5'd9, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0);
        // $0 match and unused operand never stall; rs and rt both hazarding counts once.
        drive(5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd2, 5'd0, 2'd1, 1'b0, 1'b0);
        drive(5'd4, 5'd0, 2'd3, 2'd3, 1'b0, 5'd4, 2'd2, 5'd4, 2'd1, 1'b0, 1'b0);
        drive(5'd5, 5'd5, 2'd0, 2'd0, 1'b0, 5'd5, 2'd2, 5'd5, 2'd1, 1'b0, 1'b0);
        idle(1);

        // Mult with a waiting md instruction: stalls cycles 0..5, advances in 6.
        reset_pulse();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(1);

        // Div interrupted by reset, then a fresh div reloads the full count.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        idle(3);
        reset_pulse();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        idle(3);
        // Restart while busy (count at 7) is ignored; register hazard during md stall counts once.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        drive(5'd3, 5'd0, 2'd0, 2'd3, 1'b1, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(8);

        // Randomised traffic over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rs, rt, ewa, mwa;
            logic [1:0] rtu, ttu, etn, mtn;
            rs  = 5'($urandom_range(0, 3)); rt  = 5'($urandom_range(0, 3));
            ewa = 5'($urandom_range(0, 3)); mwa = 5'($urandom_range(0, 3));
            rtu = 2'($urandom_range(0, 3)); ttu = 2'($urandom_range(0, 3));
            etn = 2'($urandom_range(0, 2)); mtn = 2'($urandom_range(0, 1));
            drive(rs, rt, rtu, ttu, 1'($urandom_range(0, 3) == 0), ewa, etn, mwa, mtn,
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            if (i == 200) reset_pulse();
        end
        idle(2);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
